vga_scan_ctrl: RTL and testbench
================================

# vga_scan_ctrl

VGA 640×480@60 scan controller for the display path. It generates the `x`/`y` scan coordinates that every sprite and hint overlay block consumes, and collects the 16-bit RGB565 `color` those blocks return. It converts that colour to the 12-bit RGB on the board pins, and delays `hs`/`vs`/`blank` so the pin outputs stay pixel-aligned with the overlay pipeline.

## Interface
Parameters:
- `PIPE_DELAY`, default 1: clock cycles from `x`/`y` change to the matching `color` being valid. Legal range 0..3; overlay blocks register their colour, giving 1.

Ports:
- `clk`  in  1: pixel clock, 25 MHz.
- `rst`  in  1: reset. Synchronous, active-high.
- `color`  in  16: RGB565 pixel from the overlay mux, sampled every cycle.
- `x`  out  10: current column, 0..639 in the active region, 0 otherwise.
- `y`  out  9: current row, 0..479 in the active region, 0 otherwise.
- `frame_start`  out  1: high for one cycle when the counters are at (0,0).
- `hs`  out  1: horizontal sync, active-low, pin-aligned.
- `vs`  out  1: vertical sync, active-low, pin-aligned.
- `blank`  out  1: high outside the active region, pin-aligned.
- `r`, `g`, `b`  out  4 each: pin colour.

## Operation
- **Counters**
  - `h_cnt` (10 b) counts 0..799 and wraps to 0.
  - `v_cnt` (10 b) increments when `h_cnt`=799 and wraps 524→0.
  - Both wraps occur on the same edge at (799,524).
- **Horizontal timing:** active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- **Vertical timing:** active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- **Scan coordinates** (combinational from the counters):
  - `x` = `h_cnt` when `h_cnt`<640, else 0.
  - `y` = `v_cnt[8:0]` when `v_cnt`<480, else 0.
- **Raw stage-0 signals:**
  - `hs_raw` = !(656≤`h_cnt`≤751).
  - `vs_raw` = !(490≤`v_cnt`≤491).
  - `act_raw` = (`h_cnt`<640 && `v_cnt`<480).
- **Alignment:** `hs_raw`, `vs_raw` and `act_raw` pass through a shift register of depth `PIPE_DELAY`+1. `blank` = !delayed `act`.
- **Colour capture:** each edge registers `r`=`color[15:12]`, `g`=`color[10:7]`, `b`=`color[4:1]`. All three are forced to 0 when the `act` tap at depth `PIPE_DELAY` is 0.
- **Frame start:** `frame_start` = (`h_cnt`==0 && `v_cnt`==0 && !`rst`).
- **Reset (`rst` high at an edge):**
  - Counters and all shift-register stages clear: `act`=0, `hs`/`vs` stages=1.
  - `r`/`g`/`b`=0, `hs`=1, `vs`=1, `blank`=1, `frame_start`=0.
  - Reset mid-frame abandons the frame. The first cycle after release is (0,0), so `frame_start`=1 in that cycle.

## Timing
- `x`, `y` and `frame_start` have zero latency relative to the counters.
- `hs`, `vs`, `blank`, `r`, `g` and `b` lag the counters by exactly `PIPE_DELAY`+1 cycles. With the default this is 2: the pixel at `x`=0 appears on the pins 2 cycles after `x` becomes 0.
- Line period is 800 cycles; frame period is 420 000 cycles.
- `hs` low width is 96 cycles. `vs` low width is 1600 cycles.
- No handshake: `color` is a free-running input that must be valid `PIPE_DELAY` cycles after each `x`/`y`.

## Configuration
- **`VGA_BORDER_TEST_EN` defined:** a 1-pixel white frame overrides `color`. The override applies when the aligned pixel has column 0 or 639, or row 0 or 479, and forces `r`=`g`=`b`=4'hF. This is the alignment check for screen setup.
- **`VGA_BORDER_TEST_EN` undefined:** no override logic. The output is purely `color`-driven.

## Test plan
- **Reset values:** hold `rst` for 5 cycles, then release.
  - During reset: `hs`=1, `vs`=1, `blank`=1, `rgb`=0, `frame_start`=0.
  - After release: `frame_start`=1 in the first cycle, `x`=0, `y`=0.
- **Sync widths and periods:** free-run 2 frames.
  - `hs` low 96 cycles every 800; `vs` low 1600 cycles every 420 000.
  - `blank` low 640 of every 800 cycles during rows 0..479.
- **Pipeline alignment:** with `PIPE_DELAY`=1, drive `color` as `x` registered by one cycle.
  - At the pin, `r` = `x[15:12]`-mapped value, with `x` taken 2 cycles earlier.
  - First active pixel: `blank` falls 2 cycles after `h_cnt` reaches 0.
- **Blanking suppression:** drive `color`=16'hFFFF constantly.
  - `r`/`g`/`b`=4'hF only while `blank`=0.
  - `r`/`g`/`b`=0 during porches and sync.
- **Reset mid-frame:** assert `rst` at `h_cnt`=300, `v_cnt`=200 for 1 cycle.
  - Next cycle: counters at (0,0), `frame_start`=1.
  - The first `hs` fall occurs 656+`PIPE_DELAY`+1 cycles after release.
- **Border macro:** with `VGA_BORDER_TEST_EN` defined and `color`=16'h0000.
  - Pins show 4'hF at columns 0/639 and rows 0/479, and 0 elsewhere.
  - Without the macro, all active pixels are 0.

Source files
------------

// File: rtl/vga_scan_ctrl_if.sv
// Scan-side bundle between vga_scan_ctrl (master) and the overlay/pin side (slave).
// Coordinates are issued every cycle; colour returns PIPE_DELAY cycles later with no handshake.
interface vga_scan_ctrl_if;
  logic [15:0] color;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        frame_start;
  logic        hs;
  logic        vs;
  logic        blank;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;

  // No valid/ready: x/y/frame_start are valid every cycle, color is sampled every cycle.
  modport master (
    input  color,
    output x, y, frame_start, hs, vs, blank, r, g, b
  );

  modport slave (
    output color,
    input  x, y, frame_start, hs, vs, blank, r, g, b
  );
endinterface

// File: rtl/vga_scan_ctrl.sv
// VGA 640x480@60 scan controller: counters, coordinates, pin-aligned sync/blank and RGB565->RGB444.
// Optional macro VGA_BORDER_TEST_EN forces a 1-pixel white frame onto the pins.
module vga_scan_ctrl #(
  parameter int PIPE_DELAY = 1
) (
  input  logic            clk,
  input  logic            rst,
  vga_scan_ctrl_if.master vga
);

  localparam logic [9:0] H_LAST    = 10'd799;
  localparam logic [9:0] H_ACTIVE  = 10'd640;
  localparam logic [9:0] H_SYNC_LO = 10'd656;
  localparam logic [9:0] H_SYNC_HI = 10'd751;
  localparam logic [9:0] V_LAST    = 10'd524;
  localparam logic [9:0] V_ACTIVE  = 10'd480;
  localparam logic [9:0] V_SYNC_LO = 10'd490;
  localparam logic [9:0] V_SYNC_HI = 10'd491;

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q + 10'd1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = 10'd0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end
  end

  logic hs_raw, vs_raw, act_raw;
  assign hs_raw  = !((h_cnt_q >= H_SYNC_LO) && (h_cnt_q <= H_SYNC_HI));
  assign vs_raw  = !((v_cnt_q >= V_SYNC_LO) && (v_cnt_q <= V_SYNC_HI));
  assign act_raw = (h_cnt_q < H_ACTIVE) && (v_cnt_q < V_ACTIVE);

  // tap[k] is the raw signal delayed by k cycles; tap[0] is the raw signal itself.
  logic [PIPE_DELAY:0]   act_sr_q, hs_sr_q, vs_sr_q;
  logic [PIPE_DELAY+1:0] act_tap, hs_tap, vs_tap;
  assign act_tap = {act_sr_q, act_raw};
  assign hs_tap  = {hs_sr_q, hs_raw};
  assign vs_tap  = {vs_sr_q, vs_raw};

  logic [11:0] rgb_q, rgb_d;
  logic        unused_color_bits;

`ifdef VGA_BORDER_TEST_EN
  logic                  brd_raw;
  logic [PIPE_DELAY:0]   brd_sr_q;
  logic [PIPE_DELAY+1:0] brd_tap;
  assign brd_raw = act_raw && ((h_cnt_q == 10'd0) || (h_cnt_q == H_ACTIVE - 10'd1) ||
                               (v_cnt_q == 10'd0) || (v_cnt_q == V_ACTIVE - 10'd1));
  assign brd_tap = {brd_sr_q, brd_raw};
  assign unused_color_bits = ^{vga.color[11], vga.color[6:5], vga.color[0], brd_tap[PIPE_DELAY+1]};

  always_ff @(posedge clk) begin
    if (rst) brd_sr_q <= '0;
    else     brd_sr_q <= brd_tap[PIPE_DELAY:0];
  end
`else
  assign unused_color_bits = ^{vga.color[11], vga.color[6:5], vga.color[0]};
`endif

  // Colour for a pixel arrives PIPE_DELAY cycles after its coordinates, so gate with that tap.
  always_comb begin
    rgb_d = act_tap[PIPE_DELAY] ? {vga.color[15:12], vga.color[10:7], vga.color[4:1]} : 12'h000;
`ifdef VGA_BORDER_TEST_EN
    if (brd_tap[PIPE_DELAY]) rgb_d = 12'hFFF;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q  <= 10'd0;
      v_cnt_q  <= 10'd0;
      act_sr_q <= '0;
      hs_sr_q  <= '1;
      vs_sr_q  <= '1;
      rgb_q    <= 12'h000;
    end else begin
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      act_sr_q <= act_tap[PIPE_DELAY:0];
      hs_sr_q  <= hs_tap[PIPE_DELAY:0];
      vs_sr_q  <= vs_tap[PIPE_DELAY:0];
      rgb_q    <= rgb_d;
    end
  end

  assign vga.x           = (h_cnt_q < H_ACTIVE) ? h_cnt_q : 10'd0;
  assign vga.y           = (v_cnt_q < V_ACTIVE) ? v_cnt_q[8:0] : 9'd0;
  assign vga.frame_start = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0) && !rst;
  assign vga.hs          = hs_tap[PIPE_DELAY+1];
  assign vga.vs          = vs_tap[PIPE_DELAY+1];
  assign vga.blank       = !act_tap[PIPE_DELAY+1];
  assign vga.r           = rgb_q[11:8];
  assign vga.g           = rgb_q[7:4];
  assign vga.b           = rgb_q[3:0];

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl (PIPE_DELAY=1): reference timing model feeds an expected-pin queue.
// Also checks hs/blank widths and periods, reset values and mid-line reset recovery.
module tb_vga_scan_ctrl;

  localparam logic [14:0] RESET_PINS = 15'h7000;

  logic clk;
  logic rst;
  vga_scan_ctrl_if vif ();

  vga_scan_ctrl #(.PIPE_DELAY(1)) dut (
    .clk (clk),
    .rst (rst),
    .vga (vif.master)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  int n_vec;
  int n_fail;
  logic [14:0] exp_q[$];

  logic [9:0] h_m, v_m, ph_m, pv_m;
  bit         prev_valid;
  int         cyc, last_fall, blow;
  bit         prev_hs, prev_blank, seen_fall, seen_bfall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [14:0] exp_pins(input logic [9:0] h, input logic [9:0] v, input logic [15:0] c);
    logic act, hs, vs;
    logic [11:0] rgb;
    act = (h < 10'd640) && (v < 10'd480);
    hs  = !(h >= 10'd656 && h <= 10'd751);
    vs  = !(v >= 10'd490 && v <= 10'd491);
    rgb = act ? {c[15:12], c[10:7], c[4:1]} : 12'h000;
`ifdef VGA_BORDER_TEST_EN
    if (act && (h == 10'd0 || h == 10'd639 || v == 10'd0 || v == 10'd479)) rgb = 12'hFFF;
`endif
    return {hs, vs, !act, rgb};
  endfunction

  function automatic logic [15:0] pick_color(input int mode);
    if (mode == 0) return 16'($urandom_range(0, 16'hFFFF));
    if (mode == 1) return 16'hFFFF;
    return 16'h0000;
  endfunction

  task automatic check_cycle(input logic [15:0] c);
    logic [9:0]  x_exp;
    logic [8:0]  y_exp;
    logic        fs_exp;
    logic [14:0] pins, e;
    x_exp  = (h_m < 10'd640) ? h_m : 10'd0;
    y_exp  = (v_m < 10'd480) ? v_m[8:0] : 9'd0;
    fs_exp = (h_m == 10'd0) && (v_m == 10'd0);
    chk("xy_fs", {12'd0, vif.x, vif.y, vif.frame_start}, {12'd0, x_exp, y_exp, fs_exp});

    pins = {vif.hs, vif.vs, vif.blank, vif.r, vif.g, vif.b};
    if (exp_q.size() == 0) begin
      chk("sb_empty", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      chk("pins", {17'd0, pins}, {17'd0, e});
    end

    vif.color = c;
    if (prev_valid) exp_q.push_back(exp_pins(ph_m, pv_m, c));
    else            exp_q.push_back(RESET_PINS);
    ph_m = h_m;
    pv_m = v_m;
    prev_valid = 1'b1;

    if (prev_hs && !vif.hs) begin
      if (!seen_fall) chk("hs_first_fall", cyc, 658);
      else            chk("hs_period", cyc - last_fall, 800);
      seen_fall = 1'b1;
      last_fall = cyc;
    end
    if (!prev_hs && vif.hs && seen_fall) chk("hs_width", cyc - last_fall, 96);

    if (prev_blank && !vif.blank) begin
      if (!seen_bfall) chk("blank_first_fall", cyc, 2);
      seen_bfall = 1'b1;
      blow = 0;
    end
    if (!vif.blank) blow++;
    if (!prev_blank && vif.blank) chk("blank_low", blow, 640);

    prev_hs    = vif.hs;
    prev_blank = vif.blank;
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (h_m == 10'd799) begin
      h_m = 10'd0;
      v_m = (v_m == 10'd524) ? 10'd0 : v_m + 10'd1;
    end else begin
      h_m = h_m + 10'd1;
    end
  endtask

  task automatic run(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      step();
      check_cycle(pick_color(mode));
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_pins", {17'd0, vif.hs, vif.vs, vif.blank, vif.r, vif.g, vif.b}, {17'd0, RESET_PINS});
      chk("rst_xy_fs", {12'd0, vif.x, vif.y, vif.frame_start}, 32'd0);
    end
    rst = 1'b0;
    #1;
    h_m = 10'd0;
    v_m = 10'd0;
    prev_valid = 1'b0;
    exp_q.delete();
    exp_q.push_back(RESET_PINS);
    cyc = 0;
    prev_hs = 1'b1;
    prev_blank = 1'b1;
    seen_fall = 1'b0;
    seen_bfall = 1'b0;
    blow = 0;
    check_cycle(pick_color(0));
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    rst = 1'b1;
    vif.color = 16'h0000;

    do_reset(5);
    run(3199, 0);
    run(1600, 1);
    run(1600, 2);

    for (int i = 0; i < 800 && h_m != 10'd300; i++) begin
      step();
      check_cycle(pick_color(0));
    end
    chk("mid_reset_point", {22'd0, h_m}, 32'd300);
    do_reset(1);
    run(1000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
